// File: rtl/dds_load_ctrl_if.sv
// Purpose: config write channel for dds_load_ctrl (valid/ready shadow-bank writes).
// Signals:
//   cfg_valid  master->slave  write request
//   cfg_ready  slave->master  write accepted when valid & ready
//   cfg_ch     master->slave  channel index
//   cfg_field  master->slave  0=THETAS 1=DELTAS 2=AMPLS 3=illegal
//   cfg_data   master->slave  word to store
interface dds_load_ctrl_if #(
   parameter int unsigned SIG_WIDTH = 16,
   parameter int unsigned NUM_CH    = 4
);
   localparam int unsigned CH_W = $clog2(NUM_CH);

   logic                 cfg_valid;
   logic                 cfg_ready;
   logic [CH_W-1:0]      cfg_ch;
   logic [1:0]           cfg_field;
   logic [SIG_WIDTH-1:0] cfg_data;

   modport master (output cfg_valid, cfg_ch, cfg_field, cfg_data, input cfg_ready);
   modport slave  (input cfg_valid, cfg_ch, cfg_field, cfg_data, output cfg_ready);
endinterface

// File: rtl/dds_load_ctrl.sv
// Purpose: sequencer in front of the dds core. Keeps a shadow bank of per-channel
// theta/delta/ampl words, streams it into the dds shift FIFOs on commit, then
// holds dds start. The bank may be rewritten while the dds runs.
// Ports:
//   clk, i_rst          clock, synchronous active-high reset
//   cfg (slave)         config write channel (o_cfg_ready is state-only combinational)
//   i_commit, i_stop    load-and-start / stop pulses
//   o_dds_we/addrs/fifo_data  one FIFO shift per cycle during load
//   o_dds_start         dds run enable
//   o_busy, o_load_done, o_cfg_err  status
module dds_load_ctrl #(
   parameter  int unsigned SIG_WIDTH = 16,
   parameter  int unsigned NUM_CH    = 4,
   localparam int unsigned CH_W      = $clog2(NUM_CH)
) (
   input  logic                 clk,
   input  logic                 i_rst,
   dds_load_ctrl_if.slave       cfg,
   input  logic                 i_commit,
   input  logic                 i_stop,
   output logic                 o_dds_we,
   output logic [1:0]           o_dds_addrs,
   output logic [SIG_WIDTH-1:0] o_dds_fifo_data,
   output logic                 o_dds_start,
   output logic                 o_busy,
   output logic                 o_load_done,
   output logic                 o_cfg_err
);

   typedef enum logic [2:0] {
      S_IDLE, S_LD_THETA, S_LD_DELTA, S_LD_AMPL, S_RUN
   } state_t;

   localparam logic [CH_W-1:0] LAST_CH = CH_W'(NUM_CH - 1);

   state_t               r_state, w_state_n;
   logic [CH_W-1:0]      r_ch, w_ch_n;
   logic [SIG_WIDTH-1:0] r_bank [3][NUM_CH];

   logic                 w_wr_acc, w_wr_ok, w_ld_n, w_run_n;
   logic [1:0]           w_fld_n;
   logic [SIG_WIDTH-1:0] w_data_n;

   // Ready depends on state only, so the config master never sees an input-to-ready path.
   assign cfg.cfg_ready = (r_state == S_IDLE) || (r_state == S_RUN);

   assign w_wr_acc = cfg.cfg_valid && cfg.cfg_ready;
   assign w_wr_ok  = w_wr_acc && (cfg.cfg_field != 2'd3) && (32'(cfg.cfg_ch) < NUM_CH);

   // Next state, channel counter and next values of the registered outputs.
   always_comb begin
      w_state_n = r_state;
      w_ch_n    = r_ch;
      w_ld_n    = 1'b0;
      w_run_n   = 1'b0;
      w_fld_n   = 2'd0;
      w_data_n  = '0;

      case (r_state)
         S_IDLE: begin
            if (i_commit) begin
               w_state_n = S_LD_THETA;
               w_ch_n    = '0;
            end
         end
         S_LD_THETA, S_LD_DELTA, S_LD_AMPL: begin
            if (r_ch == LAST_CH) begin
               w_ch_n = '0;
               case (r_state)
                  S_LD_THETA: w_state_n = S_LD_DELTA;
                  S_LD_DELTA: w_state_n = S_LD_AMPL;
                  default:    w_state_n = S_RUN;
               endcase
            end else begin
               w_ch_n = r_ch + CH_W'(1);
            end
         end
         S_RUN: begin
            // Commit outranks stop when both arrive together.
            if (i_commit) begin
               w_state_n = S_LD_THETA;
               w_ch_n    = '0;
            end else if (i_stop) begin
               w_state_n = S_IDLE;
            end
         end
         default: begin
            w_state_n = S_IDLE;
            w_ch_n    = '0;
         end
      endcase

      w_ld_n  = (w_state_n == S_LD_THETA) || (w_state_n == S_LD_DELTA) ||
                (w_state_n == S_LD_AMPL);
      w_run_n = (w_state_n == S_RUN);

      if (w_state_n == S_LD_DELTA)     w_fld_n = 2'd1;
      else if (w_state_n == S_LD_AMPL) w_fld_n = 2'd2;
      else                             w_fld_n = 2'd0;

      // Bypass so a write accepted on the commit edge reaches the first beat.
      if (w_ld_n) begin
         if (w_wr_ok && (cfg.cfg_field == w_fld_n) && (cfg.cfg_ch == w_ch_n))
            w_data_n = cfg.cfg_data;
         else
            w_data_n = r_bank[w_fld_n][w_ch_n];
      end
   end

   // State register and registered outputs.
   always_ff @(posedge clk) begin
      if (i_rst) begin
         r_state         <= S_IDLE;
         r_ch            <= '0;
         o_dds_we        <= 1'b0;
         o_dds_addrs     <= 2'd0;
         o_dds_fifo_data <= '0;
         o_dds_start     <= 1'b0;
         o_busy          <= 1'b0;
         o_load_done     <= 1'b0;
         o_cfg_err       <= 1'b0;
      end else begin
         r_state         <= w_state_n;
         r_ch            <= w_ch_n;
         o_dds_we        <= w_ld_n;
         o_dds_addrs     <= w_ld_n ? w_fld_n : 2'd0;
         o_dds_fifo_data <= w_data_n;
         o_dds_start     <= w_run_n;
         o_busy          <= w_ld_n;
         o_load_done     <= w_run_n && (r_state != S_RUN);
         o_cfg_err       <= w_wr_acc && !w_wr_ok;
      end
   end

   // Shadow bank; only reset clears it.
   always_ff @(posedge clk) begin
      if (i_rst) begin
         foreach (r_bank[f, c]) r_bank[f][c] <= '0;
      end else if (w_wr_ok) begin
         r_bank[cfg.cfg_field][cfg.cfg_ch] <= cfg.cfg_data;
      end
   end

endmodule

// File: tb/tb_dds_load_ctrl.sv
module tb_dds_load_ctrl;
   localparam int unsigned SW   = 16;
   localparam int unsigned NCH  = 4;
   localparam int unsigned CHW  = $clog2(NCH);
   localparam int          LOAD = 3 * NCH;

   logic          clk = 1'b0;
   logic          i_rst;
   logic          i_commit, i_stop;
   logic          o_dds_we, o_dds_start, o_busy, o_load_done, o_cfg_err;
   logic [1:0]    o_dds_addrs;
   logic [SW-1:0] o_dds_fifo_data;

   int total = 0;
   int bad   = 0;

   // Reference model: the shadow bank as the spec describes it.
   logic [SW-1:0] m_bank [3][NCH];

   // Captured load window.
   logic          cap_we    [LOAD];
   logic [1:0]    cap_a     [LOAD];
   logic [SW-1:0] cap_d     [LOAD];
   logic          cap_rdy   [LOAD];
   logic          cap_start [LOAD];
   logic          cap_done_after, cap_start_after;

   always #5 clk = ~clk;

   dds_load_ctrl_if #(.SIG_WIDTH(SW), .NUM_CH(NCH)) cfg_if ();

   dds_load_ctrl #(.SIG_WIDTH(SW), .NUM_CH(NCH)) dut (
      .clk             (clk),
      .i_rst           (i_rst),
      .cfg             (cfg_if),
      .i_commit        (i_commit),
      .i_stop          (i_stop),
      .o_dds_we        (o_dds_we),
      .o_dds_addrs     (o_dds_addrs),
      .o_dds_fifo_data (o_dds_fifo_data),
      .o_dds_start     (o_dds_start),
      .o_busy          (o_busy),
      .o_load_done     (o_load_done),
      .o_cfg_err       (o_cfg_err)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // One accepted write (caller guarantees IDLE/RUN); model updated for legal writes.
   task automatic do_write(input int ch, input int fld, input logic [SW-1:0] data);
      cfg_if.cfg_valid = 1'b1;
      cfg_if.cfg_ch    = CHW'(ch);
      cfg_if.cfg_field = 2'(fld);
      cfg_if.cfg_data  = data;
      tick();
      cfg_if.cfg_valid = 1'b0;
      if (fld < 3 && ch < int'(NCH)) m_bank[fld][ch] = data;
   endtask

   task automatic pulse_commit();
      i_commit = 1'b1;
      tick();
      i_commit = 1'b0;
   endtask

   // Record the load window starting in the first load cycle, then the cycle after it.
   task automatic capture_load();
      for (int i = 0; i < LOAD; i++) begin
         cap_we[i]    = o_dds_we;
         cap_a[i]     = o_dds_addrs;
         cap_d[i]     = o_dds_fifo_data;
         cap_rdy[i]   = cfg_if.cfg_ready;
         cap_start[i] = o_dds_start;
         tick();
      end
      cap_done_after  = o_load_done;
      cap_start_after = o_dds_start;
   endtask

   task automatic test_reset();
      i_rst = 1'b1;
      repeat (2) tick();
      i_rst = 1'b0;
      total++;
      if (o_dds_we !== 1'b0 || o_dds_start !== 1'b0 || cfg_if.cfg_ready !== 1'b1 ||
          o_busy !== 1'b0 || o_load_done !== 1'b0 || o_cfg_err !== 1'b0 ||
          o_dds_addrs !== 2'd0 || o_dds_fifo_data !== '0) begin
         bad++;
         $display("FAIL reset_init: we=%b start=%b rdy=%b busy=%b done=%b err=%b, required 0 0 1 0 0 0",
                  o_dds_we, o_dds_start, cfg_if.cfg_ready, o_busy, o_load_done, o_cfg_err);
      end
      // Reset in the middle of the delta phase.
      pulse_commit();
      repeat (NCH + 1) tick();
      total++;
      if (o_busy !== 1'b1 || o_dds_addrs !== 2'd1) begin
         bad++;
         $display("FAIL reset_in_delta: busy=%b addrs=%0d, required 1 1", o_busy, o_dds_addrs);
      end
      i_rst = 1'b1;
      repeat (2) tick();
      i_rst = 1'b0;
      total++;
      if (o_dds_we !== 1'b0 || o_dds_start !== 1'b0 || cfg_if.cfg_ready !== 1'b1 || o_busy !== 1'b0) begin
         bad++;
         $display("FAIL reset_midload: we=%b start=%b rdy=%b busy=%b, required 0 0 1 0",
                  o_dds_we, o_dds_start, cfg_if.cfg_ready, o_busy);
      end
      tick();
      total++;
      if (o_dds_we !== 1'b0 || o_dds_start !== 1'b0) begin
         bad++;
         $display("FAIL reset_abort: we=%b start=%b, required 0 0", o_dds_we, o_dds_start);
      end
      // Cleared bank: a fresh load streams zeros.
      pulse_commit();
      capture_load();
      for (int i = 0; i < LOAD; i++) begin
         total++;
         if (cap_we[i] !== 1'b1 || cap_d[i] !== '0) begin
            bad++;
            $display("FAIL reset_bank_zero[%0d]: we=%b data=%h, required 1 0000", i, cap_we[i], cap_d[i]);
         end
      end
   endtask

   task automatic test_load_order();
      for (int c = 0; c < int'(NCH); c++) begin
         do_write(c, 0, SW'(16'h10 + c));
         do_write(c, 1, SW'(16'h20 + c));
         do_write(c, 2, SW'(16'h30 + c));
      end
      pulse_commit();
      capture_load();
      for (int i = 0; i < LOAD; i++) begin
         logic [1:0]    ea;
         logic [SW-1:0] ed;
         ea = 2'(i / int'(NCH));
         ed = SW'(16'h10 * (i / int'(NCH) + 1) + i % int'(NCH));
         total++;
         if (cap_we[i] !== 1'b1 || cap_a[i] !== ea || cap_d[i] !== ed) begin
            bad++;
            $display("FAIL load_order[%0d]: we=%b addrs=%0d data=%h, required 1 %0d %h",
                     i, cap_we[i], cap_a[i], cap_d[i], ea, ed);
         end
      end
      total++;
      if (cap_done_after !== 1'b1 || cap_start_after !== 1'b1 || o_dds_we !== 1'b0) begin
         bad++;
         $display("FAIL load_done: done=%b start=%b we=%b, required 1 1 0",
                  cap_done_after, cap_start_after, o_dds_we);
      end
      tick();
      total++;
      if (o_load_done !== 1'b0 || o_dds_start !== 1'b1) begin
         bad++;
         $display("FAIL load_done_pulse: done=%b start=%b, required 0 1", o_load_done, o_dds_start);
      end
   endtask

   task automatic test_same_cycle();
      cfg_if.cfg_valid = 1'b1;
      cfg_if.cfg_ch    = '0;
      cfg_if.cfg_field = 2'd0;
      cfg_if.cfg_data  = 16'hABCD;
      i_commit         = 1'b1;
      tick();
      cfg_if.cfg_valid = 1'b0;
      i_commit         = 1'b0;
      m_bank[0][0]     = 16'hABCD;
      capture_load();
      total++;
      if (cap_d[0] !== 16'hABCD) begin
         bad++;
         $display("FAIL same_cycle_first: data=%h, required abcd", cap_d[0]);
      end
      for (int i = 0; i < LOAD; i++) begin
         total++;
         if (cap_d[i] !== m_bank[i / int'(NCH)][i % int'(NCH)]) begin
            bad++;
            $display("FAIL same_cycle[%0d]: data=%h, required %h", i, cap_d[i],
                     m_bank[i / int'(NCH)][i % int'(NCH)]);
         end
      end
   endtask

   task automatic test_back_pressure();
      logic [SW-1:0] wd;
      wd = SW'($urandom);
      pulse_commit();
      cfg_if.cfg_valid = 1'b1;
      cfg_if.cfg_ch    = CHW'(1);
      cfg_if.cfg_field = 2'd1;
      cfg_if.cfg_data  = wd;
      capture_load();
      for (int i = 0; i < LOAD; i++) begin
         total++;
         if (cap_rdy[i] !== 1'b0 || cap_d[i] !== m_bank[i / int'(NCH)][i % int'(NCH)]) begin
            bad++;
            $display("FAIL backpressure[%0d]: rdy=%b data=%h, required 0 %h", i, cap_rdy[i], cap_d[i],
                     m_bank[i / int'(NCH)][i % int'(NCH)]);
         end
      end
      total++;
      if (cfg_if.cfg_ready !== 1'b1) begin
         bad++;
         $display("FAIL backpressure_run_ready: rdy=%b, required 1", cfg_if.cfg_ready);
      end
      tick();
      cfg_if.cfg_valid = 1'b0;
      m_bank[1][1]     = wd;
   endtask

   task automatic test_illegal();
      do_write(0, 3, 16'hFFFF);
      total++;
      if (o_cfg_err !== 1'b1) begin
         bad++;
         $display("FAIL illegal_err: err=%b, required 1", o_cfg_err);
      end
      tick();
      total++;
      if (o_cfg_err !== 1'b0) begin
         bad++;
         $display("FAIL illegal_err_pulse: err=%b, required 0", o_cfg_err);
      end
      pulse_commit();
      capture_load();
      for (int i = 0; i < LOAD; i++) begin
         total++;
         if (cap_d[i] !== m_bank[i / int'(NCH)][i % int'(NCH)]) begin
            bad++;
            $display("FAIL illegal_bank[%0d]: data=%h, required %h", i, cap_d[i],
                     m_bank[i / int'(NCH)][i % int'(NCH)]);
         end
      end
   endtask

   task automatic test_run_control();
      i_stop   = 1'b1;
      i_commit = 1'b1;
      tick();
      i_stop   = 1'b0;
      i_commit = 1'b0;
      capture_load();
      for (int i = 0; i < LOAD; i++) begin
         total++;
         if (cap_start[i] !== 1'b0 || cap_we[i] !== 1'b1) begin
            bad++;
            $display("FAIL stop_commit[%0d]: start=%b we=%b, required 0 1", i, cap_start[i], cap_we[i]);
         end
      end
      total++;
      if (cap_start_after !== 1'b1) begin
         bad++;
         $display("FAIL stop_commit_run: start=%b, required 1", cap_start_after);
      end
      i_stop = 1'b1;
      tick();
      i_stop = 1'b0;
      total++;
      if (o_dds_start !== 1'b0 || o_dds_we !== 1'b0 || cfg_if.cfg_ready !== 1'b1) begin
         bad++;
         $display("FAIL stop_idle: start=%b we=%b rdy=%b, required 0 0 1", o_dds_start, o_dds_we, cfg_if.cfg_ready);
      end
      i_stop = 1'b1;
      tick();
      i_stop = 1'b0;
      tick();
      total++;
      if (o_dds_start !== 1'b0 || o_dds_we !== 1'b0 || o_busy !== 1'b0) begin
         bad++;
         $display("FAIL stop_in_idle: start=%b we=%b busy=%b, required 0 0 0", o_dds_start, o_dds_we, o_busy);
      end
   endtask

   // Random write bursts then loads with stray stop/commit/valid pulses during the load.
   task automatic test_random();
      for (int it = 0; it < 20; it++) begin
         int nw;
         nw = int'($urandom_range(1, 6));
         for (int k = 0; k < nw; k++) begin
            int fld, ch;
            fld = int'($urandom_range(0, 3));
            ch  = int'($urandom_range(0, NCH - 1));
            do_write(ch, fld, SW'($urandom));
            total++;
            if (o_cfg_err !== (fld == 3)) begin
               bad++;
               $display("FAIL rand_err it%0d: err=%b, required %b", it, o_cfg_err, fld == 3);
            end
         end
         pulse_commit();
         for (int i = 0; i < LOAD; i++) begin
            total++;
            if (o_dds_we !== 1'b1 || o_dds_addrs !== 2'(i / int'(NCH)) ||
                o_dds_fifo_data !== m_bank[i / int'(NCH)][i % int'(NCH)] || cfg_if.cfg_ready !== 1'b0) begin
               bad++;
               $display("FAIL rand_load it%0d beat%0d: we=%b addrs=%0d data=%h rdy=%b, required 1 %0d %h 0",
                        it, i, o_dds_we, o_dds_addrs, o_dds_fifo_data, cfg_if.cfg_ready,
                        i / int'(NCH), m_bank[i / int'(NCH)][i % int'(NCH)]);
            end
            i_stop           = 1'($urandom_range(0, 1));
            i_commit         = 1'($urandom_range(0, 1));
            cfg_if.cfg_valid = 1'($urandom_range(0, 1));
            cfg_if.cfg_field = 2'($urandom_range(0, 2));
            cfg_if.cfg_ch    = CHW'($urandom_range(0, NCH - 1));
            cfg_if.cfg_data  = SW'($urandom);
            tick();
         end
         i_stop           = 1'b0;
         i_commit         = 1'b0;
         cfg_if.cfg_valid = 1'b0;
         total++;
         if (o_load_done !== 1'b1 || o_dds_start !== 1'b1 || o_dds_we !== 1'b0) begin
            bad++;
            $display("FAIL rand_done it%0d: done=%b start=%b we=%b, required 1 1 0",
                     it, o_load_done, o_dds_start, o_dds_we);
         end
         if ($urandom_range(0, 1) == 1) begin
            i_stop = 1'b1;
            tick();
            i_stop = 1'b0;
            total++;
            if (o_dds_start !== 1'b0) begin
               bad++;
               $display("FAIL rand_stop it%0d: start=%b, required 0", it, o_dds_start);
            end
         end
      end
   endtask

   initial begin
      i_rst            = 1'b1;
      i_commit         = 1'b0;
      i_stop           = 1'b0;
      cfg_if.cfg_valid = 1'b0;
      cfg_if.cfg_ch    = '0;
      cfg_if.cfg_field = 2'd0;
      cfg_if.cfg_data  = '0;
      foreach (m_bank[f, c]) m_bank[f][c] = '0;

      test_reset();
      test_load_order();
      test_same_cycle();
      test_back_pressure();
      test_illegal();
      test_run_control();
      test_random();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1);
   end
endmodule
